// File: rtl/asci_hex_to_block_pkg.sv
// Shared ASCII constants and FSM state encoding for the ASCII-hex <-> binary paths.
package aes_ascii_defs;

    // Character codes used by the hex decoder
    localparam logic [7:0] ASC_0   = 8'h30;  // '0'
    localparam logic [7:0] ASC_9   = 8'h39;  // '9'
    localparam logic [7:0] ASC_LA  = 8'h61;  // 'a'
    localparam logic [7:0] ASC_LF_ = 8'h66;  // 'f'
    localparam logic [7:0] ASC_UA  = 8'h41;  // 'A'
    localparam logic [7:0] ASC_UF  = 8'h46;  // 'F'
    localparam logic [7:0] ASC_SP  = 8'h20;  // space
    localparam logic [7:0] ASC_CR  = 8'h0D;  // carriage return
    localparam logic [7:0] ASC_LF  = 8'h0A;  // line feed

    // Block assembler states
    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_FULL    = 1'b1;

endpackage

// File: rtl/asci_hex_to_block_asci_bin.sv
// Combinational ASCII character classifier / hex digit decoder.
// Mirror of bin_asci; kept standalone so a command parser can reuse it.
module asci_bin
    import aes_ascii_defs::*;
(
    input  logic [7:0] rx_data,
    output logic [3:0] nib,
    output logic       is_hex,
    output logic       is_space,
    output logic       is_eol
);

    // Classify the byte; letters map to 10-15 via low nibble + 9
    always_comb begin
        nib      = 4'd0;
        is_hex   = 1'b0;
        is_space = (rx_data == ASC_SP);
        is_eol   = (rx_data == ASC_CR) || (rx_data == ASC_LF);
        if (rx_data >= ASC_0 && rx_data <= ASC_9) begin
            nib    = rx_data[3:0];
            is_hex = 1'b1;
        end else if ((rx_data >= ASC_LA && rx_data <= ASC_LF_) ||
                     (rx_data >= ASC_UA && rx_data <= ASC_UF)) begin
            nib    = rx_data[3:0] + 4'd9;
            is_hex = 1'b1;
        end
    end

endmodule

// File: rtl/asci_hex_to_block.sv
// Assembles a stream of ASCII hex characters into one 4*NIBBLES-bit block.
// First digit received lands in the most significant nibble.
module asci_hex_to_block
    import aes_ascii_defs::*;
#(
    parameter int NIBBLES = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic [4*NIBBLES-1:0]   blk_data,
    output logic                   blk_valid,
    input  logic                   blk_ready,
    output logic                   err
);

    localparam int CW = $clog2(NIBBLES + 1);
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    logic [0:0]           r_state;
    logic [CW-1:0]        r_cnt;
    logic [4*NIBBLES-1:0] r_blk;
    logic                 r_rx_ready;
    logic                 r_blk_valid;
    logic                 r_err;

    logic [3:0]           w_nib;
    logic                 w_is_hex;
    logic                 w_is_space;
    logic                 w_is_eol;
    logic                 w_acc;
    logic                 w_illegal;

    asci_bin u_dec (
        .rx_data  (rx_data),
        .nib      (w_nib),
        .is_hex   (w_is_hex),
        .is_space (w_is_space),
        .is_eol   (w_is_eol)
    );

    // rx_ready is only ever high in COLLECT, so an accept implies COLLECT
    assign w_acc     = rx_valid && r_rx_ready;
    assign w_illegal = !w_is_hex && !w_is_space && !w_is_eol;

    // Shift register: stale nibbles from a discarded partial are left in place,
    // a full block always overwrites all of them before blk_valid rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blk <= '0;
        end else if (w_acc && w_is_hex) begin
            r_blk <= {r_blk[4*NIBBLES-5:0], w_nib};
        end
    end

    // FSM, digit counter and registered handshake/err outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_COLLECT;
            r_cnt       <= '0;
            r_rx_ready  <= 1'b0;
            r_blk_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_COLLECT: begin
                    r_rx_ready  <= 1'b1;
                    r_blk_valid <= 1'b0;
                    if (w_acc) begin
                        if (w_is_hex) begin
                            if (r_cnt == LAST) begin
                                r_cnt       <= '0;
                                r_state     <= ST_FULL;
                                r_rx_ready  <= 1'b0;
                                r_blk_valid <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + CW'(1);
                            end
                        end else if (w_is_eol) begin
                            // bare EOL between blocks is harmless
                            if (r_cnt != '0) begin
                                r_err <= 1'b1;
                                r_cnt <= '0;
                            end
                        end else if (w_illegal) begin
                            r_err <= 1'b1;
                            r_cnt <= '0;
                        end
                    end
                end
                default: begin
                    // ST_FULL: block frozen until downstream takes it
                    if (blk_ready) begin
                        r_state     <= ST_COLLECT;
                        r_blk_valid <= 1'b0;
                        r_rx_ready  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign rx_ready  = r_rx_ready;
    assign blk_valid = r_blk_valid;
    assign blk_data  = r_blk;
    assign err       = r_err;

endmodule

// File: tb/tb_asci_hex_to_block.sv
// Directed bench for asci_hex_to_block with a block scoreboard.
module tb_asci_hex_to_block;

    logic         clk;
    logic         rst_n;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic [127:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic         err;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    logic [127:0] sb[$];

    localparam logic [127:0] EXP_A = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] EXP_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] EXP_C = 128'hffeeddccbbaa99887766554433221100;

    asci_hex_to_block #(.NIBBLES(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: pop the scoreboard on each block handshake, count err pulses
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (err === 1'b1) err_seen++;
            if (blk_valid === 1'b1 && blk_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_block", blk_data, 128'hx);
                end else begin
                    chk("block_data", blk_data, sb.pop_front());
                end
            end
        end
    end

    // Present one character and return #1 after the edge that accepts it
    task automatic send_char(input byte c);
        int n;
        n = 0;
        rx_data  = c;
        rx_valid = 1'b1;
        @(negedge clk);
        while (rx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (rx_ready !== 1'b1) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: observed rx_ready=%b expected 1", rx_ready);
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(tag, 128'(sb.size()), 128'd0);
    endtask

    initial begin
        int e0;
        string c_str;
        c_str     = "ffeeddccbbaa99887766554433221100";
        rst_n     = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        blk_ready = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_ready", 128'(rx_ready), 128'd0);
        chk("rst_blk_valid", 128'(blk_valid), 128'd0);
        chk("rst_blk_data", blk_data, 128'd0);
        chk("rst_err", 128'(err), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_rx_ready_low", 128'(rx_ready), 128'd0);
        @(posedge clk);
        #1;
        chk("rel_rx_ready_high", 128'(rx_ready), 128'd1);

        // back-to-back lowercase block
        sb.push_back(EXP_A);
        send_str("00112233445566778899aabbccddeeff");
        chk("t1_blk_valid", 128'(blk_valid), 128'd1);
        chk("t1_rx_ready", 128'(rx_ready), 128'd0);
        wait_drain("t1_drain");
        chk("t1_no_err", 128'(err_seen), 128'd0);

        // uppercase with spaces
        sb.push_back(EXP_B);
        send_str("2B7E1516 28AED2A6 ABF71588 09CF4F3C");
        wait_drain("t2_drain");
        chk("t2_no_err", 128'(err_seen), 128'd0);

        // partial, illegal 'g', then a full block
        send_str("00112");
        send_char(8'h67);
        chk("t3_err_pulse", 128'(err), 128'd1);
        sb.push_back(EXP_A);
        send_char("0");
        chk("t3_err_single", 128'(err), 128'd0);
        send_str("0112233445566778899aabbccddeeff");
        wait_drain("t3_drain");
        chk("t3_err_count", 128'(err_seen), 128'd1);

        // CR at cnt=0 ignored; 10 digits + LF errors
        e0 = err_seen;
        send_char(8'h0D);
        chk("t4_cr_no_err", 128'(err), 128'd0);
        send_str("0123456789");
        send_char(8'h0A);
        chk("t4_lf_err", 128'(err), 128'd1);
        sb.push_back(EXP_A);
        send_str("00112233445566778899aabbccddeeff");
        wait_drain("t4_drain");
        chk("t4_err_count", 128'(err_seen - e0), 128'd1);

        // back-pressure: block held while a character waits
        blk_ready = 1'b0;
        sb.push_back(EXP_A);
        send_str("00112233445566778899aabbccddeeff");
        rx_data  = "f";
        rx_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5_hold_rx_ready", 128'(rx_ready), 128'd0);
            chk("t5_hold_valid", 128'(blk_valid), 128'd1);
            chk("t5_hold_data", blk_data, EXP_A);
        end
        @(posedge clk);
        #1;
        blk_ready = 1'b1;
        @(posedge clk);
        #1;
        blk_ready = 1'b0;
        chk("t5_valid_fall", 128'(blk_valid), 128'd0);
        chk("t5_rx_ready_rise", 128'(rx_ready), 128'd1);
        chk("t5_popped", 128'(sb.size()), 128'd0);
        sb.push_back(EXP_C);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        send_str(c_str.substr(1, 31));
        chk("t5_second_full", 128'(blk_valid), 128'd1);
        blk_ready = 1'b1;
        wait_drain("t5_drain");

        // reset mid-block
        e0 = err_seen;
        send_str("01234567890123456");
        rst_n = 1'b0;
        #2;
        chk("t6_rst_rx_ready", 128'(rx_ready), 128'd0);
        chk("t6_rst_blk_valid", 128'(blk_valid), 128'd0);
        chk("t6_rst_blk_data", blk_data, 128'd0);
        chk("t6_rst_err", 128'(err), 128'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(EXP_C);
        send_str(c_str);
        wait_drain("t6_drain");
        repeat (3) @(posedge clk);
        #1;
        chk("t6_no_err", 128'(err_seen - e0), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
